// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg
//   Definitions shared by the PC register stage and the control unit.
//   - branch_type_t : encodings carried on branchType
//   - RESET_PC_DEFAULT : default PC after reset
//   - EXC_* : exception vector addresses selected through the PC mux
package pc_unit_pkg;

   typedef enum logic [1:0] {
      BR_BEQ = 2'b00,
      BR_BNE = 2'b01,
      BR_BLE = 2'b10,
      BR_BGT = 2'b11
   } branch_type_t;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   localparam logic [31:0] EXC_VECTOR       = 32'h8000_0180;
   localparam logic [31:0] EXC_VECTOR_BOOT  = 32'hBFC0_0380;

endpackage

// File: rtl/pc_branch_cond.sv
// pc_branch_cond
//   Combinational branch-condition evaluator, also used by the control unit.
//   Ports:
//     branchType : 00 beq, 01 bne, 10 ble, 11 bgt
//     zeroFlag   : ALU A == B
//     ltFlag     : ALU signed A < B
//     cond       : branch condition for the selected type
module pc_branch_cond
   import pc_unit_pkg::*;
(
   input  logic [1:0] branchType,
   input  logic       zeroFlag,
   input  logic       ltFlag,
   output logic       cond
);

   always_comb begin
      cond = 1'b0;
      case (branch_type_t'(branchType))
         BR_BEQ:  cond = zeroFlag;
         BR_BNE:  cond = !zeroFlag;
         BR_BLE:  cond = zeroFlag | ltFlag;
         BR_BGT:  cond = !(zeroFlag | ltFlag);
         default: cond = 1'b0;
      endcase
   end

endmodule

// File: rtl/pc_register_unit.sv
// pc_register_unit
//   PC storage stage downstream of the PC-select mux. Holds PC and EPC,
//   a PC-write counter, and registered status pulses for the control unit.
//   Optional build macro: PC_ALIGN_CHECK_EN -- when defined, writes whose
//   target has muxPCOut[1:0] != 0 are suppressed and flagged on alignErr.
//   Ports:
//     clk, reset       : rising-edge clock, async active-high reset
//     muxPCOut         : next-PC candidate
//     ALUresult        : value captured into EPC on EPCWrite
//     PCWrite          : unconditional write request (wins over PCWriteCond)
//     PCWriteCond      : branch-conditional write request
//     branchType       : branch kind (see pc_unit_pkg)
//     zeroFlag, ltFlag : ALU flags for the branch condition
//     EPCWrite         : capture ALUresult into EPC
//     PCOut, EPCOut    : current PC and exception PC
//     branchTaken      : pulse, conditional write performed last cycle
//     pcUpdated        : pulse, PC written last cycle
//     alignErr         : pulse, write blocked for misalignment last cycle
//     pcWriteCount     : writes performed since reset, wraps
module pc_register_unit
   import pc_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int unsigned CNT_W    = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      muxPCOut,
   input  logic [31:0]      ALUresult,
   input  logic             PCWrite,
   input  logic             PCWriteCond,
   input  logic [1:0]       branchType,
   input  logic             zeroFlag,
   input  logic             ltFlag,
   input  logic             EPCWrite,
   output logic [31:0]      PCOut,
   output logic [31:0]      EPCOut,
   output logic             branchTaken,
   output logic             pcUpdated,
   output logic             alignErr,
   output logic [CNT_W-1:0] pcWriteCount
);

   logic cond;
   logic misaligned;
   logic wr_req;
   logic blocked;
   logic wr_en;

   pc_branch_cond u_branch_cond (
      .branchType (branchType),
      .zeroFlag   (zeroFlag),
      .ltFlag     (ltFlag),
      .cond       (cond)
   );

`ifdef PC_ALIGN_CHECK_EN
   assign misaligned = (muxPCOut[1:0] != 2'b00);
`else
   assign misaligned = 1'b0;
`endif

   assign wr_req  = PCWrite | (PCWriteCond & cond);
   assign blocked = wr_req & misaligned;
   assign wr_en   = wr_req & !blocked;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         PCOut        <= RESET_PC;
         EPCOut       <= '0;
         branchTaken  <= 1'b0;
         pcUpdated    <= 1'b0;
         alignErr     <= 1'b0;
         pcWriteCount <= '0;
      end else begin
         if (wr_en) begin
            PCOut        <= muxPCOut;
            pcWriteCount <= pcWriteCount + CNT_W'(1);
         end
         if (EPCWrite) begin
            EPCOut <= ALUresult;
         end
         // Only a write that came from the conditional path counts as taken.
         branchTaken <= wr_en & !PCWrite & PCWriteCond;
         pcUpdated   <= wr_en;
         alignErr    <= blocked;
      end
   end

endmodule

// File: tb/tb_pc_register_unit.sv
module tb_pc_register_unit;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] epc;
      logic        taken;
      logic        upd;
      logic        aerr;
      logic [31:0] cnt;
   } exp_t;

   logic        clk;
   logic        reset;
   logic [31:0] muxPCOut;
   logic [31:0] ALUresult;
   logic        PCWrite;
   logic        PCWriteCond;
   logic [1:0]  branchType;
   logic        zeroFlag;
   logic        ltFlag;
   logic        EPCWrite;
   logic [31:0] PCOut;
   logic [31:0] EPCOut;
   logic        branchTaken;
   logic        pcUpdated;
   logic        alignErr;
   logic [31:0] pcWriteCount;

   int errors = 0;
   int checks = 0;

   exp_t        sb[$];
   logic [31:0] exp_pc;
   logic [31:0] exp_epc;
   logic [31:0] exp_cnt;

   pc_register_unit #(
      .RESET_PC (32'h0000_0000),
      .CNT_W    (32)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .muxPCOut     (muxPCOut),
      .ALUresult    (ALUresult),
      .PCWrite      (PCWrite),
      .PCWriteCond  (PCWriteCond),
      .branchType   (branchType),
      .zeroFlag     (zeroFlag),
      .ltFlag       (ltFlag),
      .EPCWrite     (EPCWrite),
      .PCOut        (PCOut),
      .EPCOut       (EPCOut),
      .branchTaken  (branchTaken),
      .pcUpdated    (pcUpdated),
      .alignErr     (alignErr),
      .pcWriteCount (pcWriteCount)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   task automatic chk_all(input string tag, input exp_t e);
      chk({tag, ".PCOut"},        PCOut,               e.pc);
      chk({tag, ".EPCOut"},       EPCOut,              e.epc);
      chk({tag, ".branchTaken"},  {31'b0, branchTaken}, {31'b0, e.taken});
      chk({tag, ".pcUpdated"},    {31'b0, pcUpdated},   {31'b0, e.upd});
      chk({tag, ".alignErr"},     {31'b0, alignErr},    {31'b0, e.aerr});
      chk({tag, ".pcWriteCount"}, pcWriteCount,        e.cnt);
   endtask

   // Monitor: one expected entry per driven cycle, compared after the edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #1;
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk_all("cycle", e);
         end
      end
   end

   task automatic drive(input logic pcw, input logic pcwc, input logic [1:0] bt,
                        input logic z, input logic l, input logic epcw,
                        input logic [31:0] alu, input logic [31:0] mux,
                        input logic exp_wr, input logic exp_tk, input logic exp_ae);
      exp_t e;
      @(negedge clk);
      #2;
      PCWrite     = pcw;
      PCWriteCond = pcwc;
      branchType  = bt;
      zeroFlag    = z;
      ltFlag      = l;
      EPCWrite    = epcw;
      ALUresult   = alu;
      muxPCOut    = mux;
      if (exp_wr) begin
         exp_pc  = mux;
         exp_cnt = exp_cnt + 32'd1;
      end
      if (epcw) exp_epc = alu;
      e.pc    = exp_pc;
      e.epc   = exp_epc;
      e.taken = exp_tk;
      e.upd   = exp_wr;
      e.aerr  = exp_ae;
      e.cnt   = exp_cnt;
      sb.push_back(e);
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic drain();
      for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
      @(negedge clk);
      #2;
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout actual=%0d required=0 pending entries", sb.size());
         sb.delete();
      end
   endtask

   // Reset asserted between clock edges; outputs must clear before any edge.
   task automatic async_reset(input string tag);
      exp_t e;
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      exp_pc  = 32'h0;
      exp_epc = 32'h0;
      exp_cnt = 32'h0;
      e.pc = 32'h0; e.epc = 32'h0; e.taken = 1'b0; e.upd = 1'b0; e.aerr = 1'b0; e.cnt = 32'h0;
      chk_all(tag, e);
      @(negedge clk);
      #1;
      reset = 1'b0;
   endtask

   // Hand-derived condition results, index = type*3 + k,
   // k: 0 -> z=0,l=0   1 -> z=0,l=1   2 -> z=1,l=0
   logic taken_tab [12] = '{1'b0, 1'b0, 1'b1,    // beq
                            1'b1, 1'b1, 1'b0,    // bne
                            1'b0, 1'b1, 1'b1,    // ble
                            1'b1, 1'b0, 1'b0};   // bgt
   logic z_tab [3] = '{1'b0, 1'b0, 1'b1};
   logic l_tab [3] = '{1'b0, 1'b1, 1'b0};

   initial begin
      exp_t e;
      reset = 1'b1;
      PCWrite = 1'b0; PCWriteCond = 1'b0; branchType = 2'b00;
      zeroFlag = 1'b0; ltFlag = 1'b0; EPCWrite = 1'b0;
      ALUresult = 32'h0; muxPCOut = 32'h0;
      exp_pc = 32'h0; exp_epc = 32'h0; exp_cnt = 32'h0;
      #11;
      e.pc = 32'h0; e.epc = 32'h0; e.taken = 1'b0; e.upd = 1'b0; e.aerr = 1'b0; e.cnt = 32'h0;
      chk_all("reset", e);
      #1;
      reset = 1'b0;

      // Unconditional write of 4
      drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0004, 1'b1, 1'b0, 1'b0);
      // beq taken to 0x40, then not taken
      drive(1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_0040, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0080, 1'b0, 1'b0, 1'b0);

      // Condition sweep, back-to-back: conditional-only, then with PCWrite overriding
      for (int t = 0; t < 4; t++) begin
         for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, 2'(t), z_tab[k], l_tab[k], 1'b0, 32'h0,
                  32'h200 + 32'(t*12 + k*4), taken_tab[t*3+k], taken_tab[t*3+k], 1'b0);
            drive(1'b1, 1'b1, 2'(t), z_tab[k], l_tab[k], 1'b0, 32'h0,
                  32'h400 + 32'(t*12 + k*4), 1'b1, 1'b0, 1'b0);
         end
      end

      // EPC and PC written in the same cycle
      drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 32'h8000_0180, 1'b1, 1'b0, 1'b0);

      // Misaligned target
`ifdef PC_ALIGN_CHECK_EN
      drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0042, 1'b0, 1'b0, 1'b1);
`else
      drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0042, 1'b1, 1'b0, 1'b0);
`endif
      idle();
      drain();

      // Build PC=0x40, count=5 from a fresh reset, then reset asynchronously
      async_reset("reset_mid1");
      drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0004, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0008, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 32'h0000_0abc, 32'h0000_000c, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0010, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0040, 1'b1, 1'b1, 1'b0);
      idle();
      drain();
      chk("pre_reset.PCOut", PCOut, 32'h0000_0040);
      chk("pre_reset.pcWriteCount", pcWriteCount, 32'd5);
      async_reset("reset_mid2");

      // First edge after reset release may already write
      drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0020, 1'b1, 1'b0, 1'b0);
      idle();
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
